// File: rtl/ring_monitor.sv
// Observer for a one-hot ring counter: encodes the hot bit and checks one-hot integrity and single-step advance.
// Counts completed laps and errors. Define RING_MONITOR_STALL_EN to accept a repeated position as a legal stall.
module ring_monitor #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int LAP_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic [N-1:0]     ring_i,
    input  logic             clr_err_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_valid_o,
    output logic             lap_o,
    output logic [LAP_W-1:0] lap_cnt_o,
    output logic             err_onehot_o,
    output logic             err_seq_o,
    output logic             err_sticky_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             lap_q, lap_d;
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
    logic             err_onehot_q, err_onehot_d;
    logic             err_seq_q, err_seq_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             onehot_ok;
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W-1:0] next_idx;
    logic             stall_ok;
    logic             any_err;
    logic [ERR_W-1:0] err_base;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign onehot_ok = (ring_i != '0) && ((ring_i & (ring_i - N'(1))) == '0);
    assign next_idx  = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef RING_MONITOR_STALL_EN
    assign stall_ok = (enc_idx == idx_q);
`else
    assign stall_ok = 1'b0;
`endif

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_i[i]) enc_idx = IDX_W'(i);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (sys_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (onehot_ok)  state_d = TRACK;
            TRACK:   if (!onehot_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d        = idx_q;
        idx_valid_d  = idx_valid_q;
        lap_d        = 1'b0;
        lap_cnt_d    = lap_cnt_q;
        err_onehot_d = 1'b0;
        err_seq_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot_ok) begin
                    idx_d       = enc_idx;
                    idx_valid_d = 1'b1;
                end else begin
                    err_onehot_d = 1'b1;
                end
            end
            TRACK: begin
                if (!onehot_ok) begin
                    err_onehot_d = 1'b1;
                    idx_valid_d  = 1'b0;
                end else if (enc_idx == next_idx) begin
                    idx_d = enc_idx;
                    if (enc_idx == '0) begin
                        lap_d     = 1'b1;
                        lap_cnt_d = lap_cnt_q + LAP_W'(1);
                    end
                end else if (!stall_ok) begin
                    err_seq_d = 1'b1;
                    idx_d     = enc_idx;
                end
            end
            default: ;
        endcase

        // An error in the same cycle as a clear wins over the clear.
        any_err      = err_onehot_d | err_seq_d;
        err_base     = clr_err_i ? '0 : err_cnt_q;
        err_cnt_d    = (any_err && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
        err_sticky_d = any_err | (err_sticky_q & ~clr_err_i);
    end

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            lap_q        <= 1'b0;
            lap_cnt_q    <= '0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            lap_q        <= lap_d;
            lap_cnt_q    <= lap_cnt_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign idx_o        = idx_q;
    assign idx_valid_o  = idx_valid_q;
    assign lap_o        = lap_q;
    assign lap_cnt_o    = lap_cnt_q;
    assign err_onehot_o = err_onehot_q;
    assign err_seq_o    = err_seq_q;
    assign err_sticky_o = err_sticky_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: directed scenarios plus randomized ring traffic against a positional reference model.
// A second instance with a 2-bit error counter observes the same stimulus to exercise saturation.
module tb_ring_monitor;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  ring;
    logic        clr_err;

    logic [2:0]  idx_a,  idx_b;
    logic        vld_a,  vld_b;
    logic        lap_a,  lap_b;
    logic [15:0] lcnt_a, lcnt_b;
    logic        eoh_a,  eoh_b;
    logic        esq_a,  esq_b;
    logic        stk_a,  stk_b;
    logic [7:0]  ecnt_a;
    logic [1:0]  ecnt_b;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the last accepted sample, tracking flag, and raw event counts.
    int m_idx, m_valid, m_lap, m_laps, m_eo, m_es, m_sticky, m_errs;

    always #5 clk = ~clk;

    ring_monitor dut_a (
        .clk_i(clk), .sys_rst_i(sys_rst), .ring_i(ring), .clr_err_i(clr_err),
        .idx_o(idx_a), .idx_valid_o(vld_a), .lap_o(lap_a), .lap_cnt_o(lcnt_a),
        .err_onehot_o(eoh_a), .err_seq_o(esq_a), .err_sticky_o(stk_a), .err_cnt_o(ecnt_a)
    );

    ring_monitor #(.ERR_W(2)) dut_b (
        .clk_i(clk), .sys_rst_i(sys_rst), .ring_i(ring), .clr_err_i(clr_err),
        .idx_o(idx_b), .idx_valid_o(vld_b), .lap_o(lap_b), .lap_cnt_o(lcnt_b),
        .err_onehot_o(eoh_b), .err_seq_o(esq_b), .err_sticky_o(stk_b), .err_cnt_o(ecnt_b)
    );

    function automatic void model_step(input logic [7:0] r, input bit c, input bit rs);
        int pos;
        bit stall_legal;
`ifdef RING_MONITOR_STALL_EN
        stall_legal = 1'b1;
`else
        stall_legal = 1'b0;
`endif
        if (rs) begin
            m_idx = 0; m_valid = 0; m_lap = 0; m_laps = 0;
            m_eo = 0; m_es = 0; m_sticky = 0; m_errs = 0;
            return;
        end
        m_lap = 0; m_eo = 0; m_es = 0;
        pos = 0;
        for (int i = 0; i < 8; i++) if (r[i]) pos = i;
        if ($countones(r) != 1) begin
            m_eo = 1;
            m_valid = 0;
        end else if (m_valid == 0) begin
            m_idx = pos;
            m_valid = 1;
        end else if (pos == (m_idx + 1) % 8) begin
            if (pos == 0) begin
                m_lap = 1;
                m_laps = (m_laps + 1) % 65536;
            end
            m_idx = pos;
        end else if (!(stall_legal && pos == m_idx)) begin
            m_es = 1;
            m_idx = pos;
        end
        if (c) begin
            m_errs = 0;
            m_sticky = 0;
        end
        if (m_eo || m_es) begin
            m_errs++;
            m_sticky = 1;
        end
    endfunction

    function automatic logic [33:0] exp_v();
        logic [7:0] s8;
        logic [1:0] s2;
        s8 = (m_errs > 255) ? 8'hFF : 8'(m_errs);
        s2 = (m_errs > 3) ? 2'd3 : 2'(m_errs);
        return {3'(m_idx), 1'(m_valid), 1'(m_lap), 16'(m_laps),
                1'(m_eo), 1'(m_es), 1'(m_sticky), s8, s2};
    endfunction

    function automatic logic [33:0] act_v();
        return {idx_a, vld_a, lap_a, lcnt_a, eoh_a, esq_a, stk_a, ecnt_a, ecnt_b};
    endfunction

    // Apply one sample at the next rising edge, then look at outputs 1ns later.
    task automatic step(input logic [7:0] r, input bit c, input bit rs);
        ring    = r;
        clr_err = c;
        sys_rst = rs;
        @(posedge clk);
        #1;
        model_step(r, c, rs);
    endtask

    task automatic test_reset();
        step(8'($urandom), 1'b0, 1'b1);
        checks++;
        if (act_v() !== 34'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", act_v(), 34'h0);
        end
    endtask

    task automatic test_lap();
        logic [7:0] seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        step(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(seq[i], 1'b0, 1'b0);
            checks++;
            if (act_v() !== exp_v()) begin
                errors++;
                $display("FAIL lap_walk[%0d]: got %h want %h", i, act_v(), exp_v());
            end
        end
        checks++;
        if ({lap_a, lcnt_a, idx_a, stk_a} !== {1'b1, 16'd1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL lap_final: got lap=%0b cnt=%0d idx=%0d stk=%0b want 1 1 0 0",
                     lap_a, lcnt_a, idx_a, stk_a);
        end
    endtask

    task automatic test_onehot_err();
        logic [7:0] seq [4] = '{8'h01, 8'h02, 8'h24, 8'h08};
        step(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b0, 1'b0);
            checks++;
            if (act_v() !== exp_v()) begin
                errors++;
                $display("FAIL onehot_err[%0d]: got %h want %h", i, act_v(), exp_v());
            end
            if (i == 2) begin
                checks++;
                if ({eoh_a, vld_a, idx_a, ecnt_a, stk_a} !== {1'b1, 1'b0, 3'd1, 8'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL onehot_pulse: got eoh=%0b vld=%0b idx=%0d cnt=%0d stk=%0b want 1 0 1 1 1",
                             eoh_a, vld_a, idx_a, ecnt_a, stk_a);
                end
            end
        end
        checks++;
        if ({idx_a, vld_a, esq_a} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reacquire: got idx=%0d vld=%0b seq=%0b want 3 1 0", idx_a, vld_a, esq_a);
        end
    endtask

    task automatic test_seq_err();
        step(8'h01, 1'b0, 1'b1);
        step(8'h02, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        checks++;
        if ({esq_a, idx_a, ecnt_a, lap_a} !== {1'b1, 3'd3, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL seq_skip: got seq=%0b idx=%0d cnt=%0d lap=%0b want 1 3 1 0",
                     esq_a, idx_a, ecnt_a, lap_a);
        end
        checks++;
        if (act_v() !== exp_v()) begin
            errors++;
            $display("FAIL seq_model: got %h want %h", act_v(), exp_v());
        end
    endtask

    task automatic test_stall();
        logic exp_seq;
`ifdef RING_MONITOR_STALL_EN
        exp_seq = 1'b0;
`else
        exp_seq = 1'b1;
`endif
        step(8'h01, 1'b0, 1'b1);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        checks++;
        if ({esq_a, idx_a} !== {exp_seq, 3'd2}) begin
            errors++;
            $display("FAIL stall_repeat: got seq=%0b idx=%0d want %0b 2", esq_a, idx_a, exp_seq);
        end
        step(8'h08, 1'b0, 1'b0);
        checks++;
        if (act_v() !== exp_v() || idx_a !== 3'd3) begin
            errors++;
            $display("FAIL stall_next: got %h want %h", act_v(), exp_v());
        end
    endtask

    task automatic test_clear();
        step(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
        checks++;
        if ({ecnt_a, ecnt_b} !== {8'd5, 2'd3}) begin
            errors++;
            $display("FAIL clear_pre: got cnt=%0d cnt2=%0d want 5 3", ecnt_a, ecnt_b);
        end
        step(8'h00, 1'b1, 1'b0);
        checks++;
        if ({ecnt_a, stk_a} !== {8'd1, 1'b1}) begin
            errors++;
            $display("FAIL clear_vs_err: got cnt=%0d stk=%0b want 1 1", ecnt_a, stk_a);
        end
        step(8'h01, 1'b1, 1'b0);
        checks++;
        if ({ecnt_a, ecnt_b, stk_a, vld_a} !== {8'd0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL clear_alone: got cnt=%0d cnt2=%0d stk=%0b vld=%0b want 0 0 0 1",
                     ecnt_a, ecnt_b, stk_a, vld_a);
        end
    endtask

    task automatic test_saturate_and_reset();
        logic [7:0] pat;
        step(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) step((i % 2) ? 8'h00 : 8'hC3, 1'b0, 1'b0);
        checks++;
        if ({ecnt_a, ecnt_b, stk_a} !== {8'hFF, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d cnt2=%0d stk=%0b want 255 3 1", ecnt_a, ecnt_b, stk_a);
        end
        for (int i = 0; i < 25; i++) begin
            pat = 8'h01 << (i % 8);
            step(pat, 1'b0, 1'b0);
        end
        checks++;
        if (lcnt_a !== 16'd3 || act_v() !== exp_v()) begin
            errors++;
            $display("FAIL three_laps: got cnt=%0d vec=%h want 3 vec=%h", lcnt_a, act_v(), exp_v());
        end
        step(8'h02, 1'b0, 1'b1);
        checks++;
        if (act_v() !== 34'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", act_v(), 34'h0);
        end
        step(8'h01, 1'b0, 1'b0);
        checks++;
        if ({lap_a, esq_a, idx_a, vld_a, lcnt_a} !== {1'b0, 1'b0, 3'd0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL post_reset: got lap=%0b seq=%0b idx=%0d vld=%0b cnt=%0d want 0 0 0 1 0",
                     lap_a, esq_a, idx_a, vld_a, lcnt_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int sel, a, b;
        bit c, rs;
        step(8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            if (sel < 70)      r = 8'h01 << ((m_idx + 1) % 8);
            else if (sel < 78) r = 8'h01 << m_idx;
            else if (sel < 86) r = 8'h01 << a;
            else if (sel < 92) r = 8'h00;
            else               r = (8'h01 << a) | (8'h01 << b);
            c  = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(r, c, rs);
            checks++;
            if (act_v() !== exp_v()) begin
                errors++;
                $display("FAIL random[%0d] ring=%h clr=%0b rst=%0b: got %h want %h",
                         i, r, c, rs, act_v(), exp_v());
            end
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        ring    = 8'h01;
        clr_err = 1'b0;
        model_step(8'h01, 1'b0, 1'b1);
        test_reset();
        test_lap();
        test_onehot_err();
        test_seq_err();
        test_stall();
        test_clear();
        test_saturate_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
Downstream consumer of the 8-stage one-hot ring counter. It samples the ring output every clock and encodes it to a binary index. It checks one-hot integrity and that each step is a legal single-position advance, then counts full revolutions (laps) and errors. The results drive LEDs/debug outputs on the FPGA board and give the bench a self-checking observer.

Parameters:
N, 8, ring width in bits (number of ring stages); must be >= 2
IDX_W, $clog2(N) (3), width of encoded index
LAP_W, 16, width of lap counter (wraps modulo 2^LAP_W)
ERR_W, 8, width of error counter (saturating)

Ports:
clk_i  input  1  system clock; all logic on rising edge
sys_rst_i  input  1  synchronous, active-high reset
ring_i  input  N  one-hot ring counter value (ring counter holds 8'h01 during reset)
clr_err_i  input  1  synchronous clear of err_sticky_o and err_cnt_o
idx_o  output  IDX_W  binary position of the hot bit
idx_valid_o  output  1  1 when idx_o reflects a valid one-hot sample
lap_o  output  1  one-cycle pulse on legal wrap N-1 -> 0
lap_cnt_o  output  LAP_W  number of completed laps
err_onehot_o  output  1  one-cycle pulse: sample was zero or multi-hot
err_seq_o  output  1  one-cycle pulse: valid sample but not prev+1 mod N
err_sticky_o  output  1  set on any error, held until clr_err_i or reset
err_cnt_o  output  ERR_W  total errors, saturates at all-ones

Behaviour:
- Single-stage registered: ring_i sampled at edge k, all outputs reflect that sample after edge k; latency 1 clock.
- Reset (sys_rst_i=1 at an edge): all outputs 0, state IDLE; ring_i ignored during reset. Reset mid-operation discards all history, including lap and error counts.
- Encoding: ring_i valid iff exactly one bit set; idx_o = index of that bit (bit 0 -> 0).
- State IDLE: on valid sample load idx_o, set idx_valid_o=1, go TRACK; no sequence check, no lap. On invalid sample: err_onehot_o pulse, stay IDLE.
- State TRACK, valid sample:
  - idx == prev+1 mod N: legal advance; update idx_o. If prev==N-1 and idx==0, pulse lap_o and increment lap_cnt_o (wraps to 0 after 2^LAP_W-1).
  - Otherwise: err_seq_o pulse; idx_o updates to new value (resync); stay TRACK; no lap pulse.
- State TRACK, invalid sample (zero or multi-hot): err_onehot_o pulse, idx_valid_o=0, idx_o holds last value, go IDLE (reacquire).
- err_onehot_o and err_seq_o are mutually exclusive in any cycle.
- Any error pulse sets err_sticky_o and increments err_cnt_o by 1, saturating at 2^ERR_W-1.
- clr_err_i: clears err_sticky_o and err_cnt_o. If an error occurs in the same cycle, the error wins: err_cnt_o=1, err_sticky_o=1.
- clr_err_i does not affect state, idx_o, or the lap counter.

Optional Feature:
Macro RING_MONITOR_STALL_EN.
- Defined: in TRACK, a valid sample equal to prev is a legal stall (supports an enable-gated ring). No error, no lap, idx_o unchanged.
- Not defined: a repeated sample is a sequence error (err_seq_o pulse).

Test Plan:
1. Reset, then ring_i = 01,02,04,08,10,20,40,80,01 one per clock -> idx_o 0..7,0; idx_valid_o 1 from first sample; lap_o single pulse on final 01; lap_cnt_o=1; no error outputs.
2. In TRACK at idx 1, drive 8'h24 then 8'h08 -> err_onehot_o pulse, idx_valid_o=0, idx_o=1, err_cnt_o=1, err_sticky_o=1. Next cycle: idx_o=3, idx_valid_o=1, no err_seq_o (reacquire from IDLE).
3. Drive 02 then 08 in TRACK -> err_seq_o pulse with idx_o=3; err_cnt_o increments by 1; no lap_o.
4. Drive 04,04,08. Without macro: err_seq_o on second 04. With RING_MONITOR_STALL_EN: no error, idx_o 2,2,3.
5. With err_cnt_o=5, assert clr_err_i together with ring_i=8'h00 -> err_cnt_o=1, err_sticky_o=1. Then clr_err_i alone -> both 0.
6. ERR_W=2, inject 5 invalid samples -> err_cnt_o saturates at 3. Then assert sys_rst_i for one clock after lap_cnt_o=3 -> all outputs 0 next cycle, and the first sample after reset produces no lap_o or err_seq_o.
